// File: rtl/ldtu_sample_encoder.sv
// rtl/ldtu_sample_encoder.sv - packs baseline/signal samples into 32-bit words
// and buffers them in a first-word-fall-through output FIFO.
module ldtu_sample_encoder #(
  parameter int OutDepth = 8,
  parameter int NBitsLvl = 4
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                DIN_VALID,
  input  logic [12:0]         DATA_in,
  input  logic                baseline_flag,
  output logic [31:0]         DOUT,
  output logic                DOUT_VALID,
  input  logic                DOUT_READY,
  output logic [NBitsLvl-1:0] FIFO_LEVEL,
  output logic                OVERFLOW
);

  localparam int AW = $clog2(OutDepth);

  typedef enum logic {BASE = 1'b0, SIG = 1'b1} mode_t;

  mode_t       mode_q, mode_n;
  logic [2:0]  cnt_q, cnt_n;
  logic [23:0] base_q, base_n;
  logic [12:0] sig_q, sig_n;
  logic        emit;
  logic [31:0] word;
  logic        word_vld_q;
  logic [31:0] word_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mode_q     <= BASE;
      cnt_q      <= 3'd0;
      base_q     <= 24'd0;
      sig_q      <= 13'd0;
      word_vld_q <= 1'b0;
      word_q     <= 32'd0;
    end else begin
      mode_q     <= mode_n;
      cnt_q      <= cnt_n;
      base_q     <= base_n;
      sig_q      <= sig_n;
      word_vld_q <= emit;
      word_q     <= word;
    end
  end

  // Starting a fresh baseline buffer clears the upper slots so partial words carry zeros.
  always_comb begin
    mode_n = mode_q;
    cnt_n  = cnt_q;
    base_n = base_q;
    sig_n  = sig_q;
    if (DIN_VALID) begin
      if (baseline_flag) begin
        if (mode_q == SIG || cnt_q == 3'd0) begin
          mode_n = BASE;
          cnt_n  = 3'd1;
          base_n = {18'd0, DATA_in[5:0]};
        end else if (cnt_q == 3'd4) begin
          cnt_n = 3'd0;
        end else begin
          cnt_n = cnt_q + 3'd1;
          case (cnt_q)
            3'd1:    base_n[11:6]  = DATA_in[5:0];
            3'd2:    base_n[17:12] = DATA_in[5:0];
            3'd3:    base_n[23:18] = DATA_in[5:0];
            default: base_n        = base_q;
          endcase
        end
      end else begin
        if (mode_q == BASE || cnt_q == 3'd0) begin
          mode_n = SIG;
          cnt_n  = 3'd1;
          sig_n  = DATA_in;
        end else begin
          cnt_n = 3'd0;
        end
      end
    end
  end

  always_comb begin
    emit = 1'b0;
    word = 32'd0;
    if (DIN_VALID) begin
      if (baseline_flag) begin
        if (mode_q == SIG && cnt_q == 3'd1) begin
          emit = 1'b1;
          word = {6'b001011, 13'd0, sig_q};
        end else if (mode_q == BASE && cnt_q == 3'd4) begin
          emit = 1'b1;
          word = {2'b01, DATA_in[5:0], base_q};
        end
      end else begin
        if (mode_q == BASE && cnt_q != 3'd0) begin
          emit = 1'b1;
          word = {2'b10, cnt_q, 3'b000, base_q};
        end else if (mode_q == SIG && cnt_q == 3'd1) begin
          emit = 1'b1;
          word = {6'b001010, DATA_in, sig_q};
        end
      end
    end
  end

  logic [31:0]         mem [OutDepth];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [NBitsLvl-1:0] level;
  logic                full, empty, pop, push_ok;

  assign full    = (level == NBitsLvl'(OutDepth));
  assign empty   = (level == '0);
  assign pop     = !empty && DOUT_READY;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok = word_vld_q && (!full || pop);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      level <= level + NBitsLvl'(1);
      else if (!push_ok && pop) level <= level - NBitsLvl'(1);
      if (word_vld_q && full && !pop) OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= word_q;
  end

  assign DOUT       = empty ? 32'd0 : mem[rd_ptr];
  assign DOUT_VALID = !empty;
  assign FIFO_LEVEL = level;

endmodule

// File: tb/tb_ldtu_sample_encoder.sv
// tb/tb_ldtu_sample_encoder.sv - scoreboard bench for ldtu_sample_encoder.
module tb_ldtu_sample_encoder;

  logic        CLK = 1'b0;
  logic        rst;
  logic        DIN_VALID;
  logic [12:0] DATA_in;
  logic        baseline_flag;
  logic [31:0] DOUT;
  logic        DOUT_VALID;
  logic        DOUT_READY;
  logic [3:0]  FIFO_LEVEL;
  logic        OVERFLOW;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] alt_exp [9];

  always #5 CLK = ~CLK;

  ldtu_sample_encoder #(.OutDepth(8), .NBitsLvl(4)) dut (
    .CLK(CLK), .rst(rst), .DIN_VALID(DIN_VALID), .DATA_in(DATA_in),
    .baseline_flag(baseline_flag), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY), .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!rst && DOUT_VALID && DOUT_READY) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%08h expected none", DOUT);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("dout_word", DOUT, mon_exp);
      end
    end
  end

  task automatic send(input logic b, input logic [12:0] d);
    baseline_flag = b;
    DATA_in       = d;
    DIN_VALID     = 1'b1;
    @(posedge CLK); #1;
    DIN_VALID     = 1'b0;
    DATA_in       = 13'h1555;
  endtask

  task automatic idle(input int n);
    DIN_VALID     = 1'b0;
    DATA_in       = 13'h1555;
    baseline_flag = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic alt(input int i);
    if (i % 2 == 0) send(1'b1, 13'(i + 1));
    else            send(1'b0, 13'(32'h100 + i));
  endtask

  task automatic do_reset;
    DOUT_READY = 1'b0;
    DIN_VALID  = 1'b0;
    rst        = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    exp_q.delete();
    chk("rst_dout", DOUT, 32'd0);
    chk("rst_valid", 32'(DOUT_VALID), 32'd0);
    chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("rst_overflow", 32'(OVERFLOW), 32'd0);
    rst = 1'b0;
  endtask

  task automatic drain;
    int c;
    logic done;
    done = 1'b0;
    c = 0;
    DOUT_READY = 1'b1;
    while (!done && c < 40) begin
      @(posedge CLK); #1;
      c++;
      if (FIFO_LEVEL == 4'd0 && exp_q.size() == 0) done = 1'b1;
    end
    DOUT_READY = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: level %0d, %0d words still expected", FIFO_LEVEL, exp_q.size());
    end
    chk("drained_valid", 32'(DOUT_VALID), 32'd0);
    chk("drained_dout", DOUT, 32'd0);
  endtask

  initial begin
    alt_exp[0] = 32'h88000001;
    alt_exp[1] = 32'h2C000101;
    alt_exp[2] = 32'h88000003;
    alt_exp[3] = 32'h2C000103;
    alt_exp[4] = 32'h88000005;
    alt_exp[5] = 32'h2C000105;
    alt_exp[6] = 32'h88000007;
    alt_exp[7] = 32'h2C000107;
    alt_exp[8] = 32'h88000009;
    rst = 1'b1; DIN_VALID = 1'b0; DATA_in = 13'd0; baseline_flag = 1'b0; DOUT_READY = 1'b0;
    do_reset;

    // full baseline word and one-cycle latency
    for (int v = 1; v <= 5; v++) send(1'b1, 13'(v));
    exp_q.push_back(32'h45103081);
    chk("latency_not_yet", 32'(DOUT_VALID), 32'd0);
    @(posedge CLK); #1;
    chk("base_full_dout", DOUT, 32'h45103081);
    chk("base_full_valid", 32'(DOUT_VALID), 32'd1);
    chk("base_full_level", 32'(FIFO_LEVEL), 32'd1);
    drain;

    // full signal word
    send(1'b0, 13'h1ABC);
    send(1'b0, 13'h0123);
    exp_q.push_back(32'h28247ABC);
    @(posedge CLK); #1;
    chk("sig_full_dout", DOUT, 32'h28247ABC);
    drain;

    // partial baseline then single-signal word
    send(1'b1, 13'd7);
    send(1'b1, 13'd9);
    send(1'b0, 13'h0FFF);
    exp_q.push_back(32'h90000247);
    send(1'b1, 13'd0);
    exp_q.push_back(32'h2C000FFF);
    @(posedge CLK); #1;
    chk("switch_level", 32'(FIFO_LEVEL), 32'd2);
    chk("partial_dout", DOUT, 32'h90000247);
    drain;

    // overflow with alternating flag
    do_reset;
    for (int i = 0; i < 20; i++) begin
      alt(i);
      if (i >= 1 && i <= 8) exp_q.push_back(alt_exp[i-1]);
    end
    @(posedge CLK); #1;
    chk("ovf_level", 32'(FIFO_LEVEL), 32'd8);
    chk("ovf_flag", 32'(OVERFLOW), 32'd1);
    chk("ovf_head", DOUT, alt_exp[0]);
    drain;
    chk("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // full FIFO with simultaneous push and pop
    do_reset;
    for (int i = 0; i < 9; i++) begin
      alt(i);
      if (i >= 1) exp_q.push_back(alt_exp[i-1]);
    end
    @(posedge CLK); #1;
    chk("full_level", 32'(FIFO_LEVEL), 32'd8);
    alt(9);
    exp_q.push_back(alt_exp[8]);
    DOUT_READY = 1'b1;
    @(posedge CLK); #1;
    DOUT_READY = 1'b0;
    chk("pushpop_level", 32'(FIFO_LEVEL), 32'd8);
    chk("pushpop_overflow", 32'(OVERFLOW), 32'd0);
    drain;

    // DIN_VALID gaps inside a baseline run; upper data bits must be ignored
    do_reset;
    for (int v = 10; v <= 14; v++) begin
      send(1'b1, 13'h1FC0 | 13'(v));
      if (v < 14) idle(2);
    end
    chk("gap_no_early", 32'(FIFO_LEVEL), 32'd0);
    exp_q.push_back(32'h4E34C2CA);
    @(posedge CLK); #1;
    chk("gap_dout", DOUT, 32'h4E34C2CA);
    drain;

    // reset asserted with data buffered and 3 samples pending
    for (int v = 1; v <= 5; v++) send(1'b1, 13'(v));
    send(1'b1, 13'd20);
    send(1'b1, 13'd21);
    send(1'b1, 13'd22);
    chk("pre_rst_valid", 32'(DOUT_VALID), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dout", DOUT, 32'd0);
    chk("async_rst_valid", 32'(DOUT_VALID), 32'd0);
    chk("async_rst_level", 32'(FIFO_LEVEL), 32'd0);
    exp_q.delete();
    @(posedge CLK); #1;
    rst = 1'b0;
    for (int v = 1; v <= 5; v++) send(1'b1, 13'(v));
    exp_q.push_back(32'h45103081);
    @(posedge CLK); #1;
    chk("post_rst_dout", DOUT, 32'h45103081);
    chk("post_rst_level", 32'(FIFO_LEVEL), 32'd1);
    drain;

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
